// File: rtl/z80_bus_master.sv
// Z80 bus-cycle initiator: turns simple commands into M1 / MEM / IO cycles on the buffered
// Z80 bus, with WAIT_N stretching, refresh addressing and BUSRQ_N/BUSAK_N bus handoff.
module z80_bus_master #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int REFRESH_BITS = 7
) (
    input  logic        B_PHI,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] BA,
    output logic [7:0]  BD_O,
    output logic        BD_OE,
    input  logic [7:0]  BD_I,
    output logic        BMREQ_N,
    output logic        IORQ_N,
    output logic        BRD_N,
    output logic        N_BWR,
    output logic        BM1_N,
    output logic        BRFSH_N,
    output logic        BUS_OE,
    input  logic        WAIT_N,
    input  logic        BUSRQ_N,
    output logic        BUSAK_N
);

    localparam int WCW = $clog2(WAIT_TIMEOUT + 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_T4, ST_BREL
    } state_e;

    typedef enum logic [2:0] {
        CMD_M1   = 3'd0,
        CMD_MRD  = 3'd1,
        CMD_MWR  = 3'd2,
        CMD_IORD = 3'd3,
        CMD_IOWR = 3'd4
    } cmd_e;

    state_e                  state_q, state_d;
    cmd_e                    kind_q, kind_d;
    logic [15:0]             addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [REFRESH_BITS-1:0] rfsh_q, rfsh_d;

    logic        done, abort;
    logic [7:0]  done_rdata;
    logic        is_io_q;

    logic        cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic [7:0]  rsp_rdata_d, bd_o_d;
    logic [15:0] ba_d;
    logic        bd_oe_d, mreq_n_d, iorq_n_d, rd_n_d, wr_n_d, m1_n_d, rfsh_n_d;
    logic        bus_oe_d, busak_n_d;

    assign is_io_q = (kind_q == CMD_IORD) || (kind_q == CMD_IOWR);

    // Sequencing: one pass per T-state.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        opcode_d   = opcode_q;
        wait_cnt_d = wait_cnt_q;
        rfsh_d     = rfsh_q;
        done       = 1'b0;
        abort      = 1'b0;
        done_rdata = 8'h00;
        case (state_q)
            ST_IDLE: begin
                // A bus request pre-empts the handshake; the command stays pending.
                if (!BUSRQ_N) begin
                    state_d = ST_BREL;
                end else if (cmd_valid) begin
                    if (cmd_type > 3'd4) begin
                        done  = 1'b1;
                        abort = 1'b1;
                    end else begin
                        state_d = ST_T1;
                        kind_d  = cmd_e'(cmd_type);
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                    end
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                wait_cnt_d = WCW'(1);
                if (is_io_q || !WAIT_N) begin
                    state_d = ST_TW;
                end else begin
                    state_d  = ST_T3;
                    opcode_d = BD_I;
                end
            end
            ST_TW: begin
                if (WAIT_N) begin
                    state_d  = ST_T3;
                    opcode_d = BD_I;
                end else if (WAIT_TIMEOUT != 0 && wait_cnt_q >= WCW'(WAIT_TIMEOUT)) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    abort   = 1'b1;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_T3: begin
                if (kind_q == CMD_M1) begin
                    state_d = ST_T4;
                end else begin
                    done = 1'b1;
                    if (kind_q == CMD_MRD || kind_q == CMD_IORD) done_rdata = BD_I;
                    state_d = BUSRQ_N ? ST_IDLE : ST_BREL;
                end
            end
            ST_T4: begin
                rfsh_d     = rfsh_q + REFRESH_BITS'(1);
                done       = 1'b1;
                done_rdata = opcode_q;
                state_d    = BUSRQ_N ? ST_IDLE : ST_BREL;
            end
            ST_BREL: if (BUSRQ_N) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ba_d        = '0;
        bd_o_d      = '0;
        bd_oe_d     = 1'b0;
        mreq_n_d    = 1'b1;
        iorq_n_d    = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        m1_n_d      = 1'b1;
        rfsh_n_d    = 1'b1;
        bus_oe_d    = 1'b1;
        busak_n_d   = 1'b1;
        cmd_ready_d = 1'b0;
        rsp_valid_d = done;
        rsp_err_d   = abort;
        rsp_rdata_d = done_rdata;
        case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_BREL: begin
                busak_n_d = 1'b0;
                bus_oe_d  = 1'b0;
            end
            default: begin
                case (kind_d)
                    CMD_M1: begin
                        mreq_n_d = 1'b0;
                        if (state_d == ST_T3 || state_d == ST_T4) begin
                            rfsh_n_d                  = 1'b0;
                            ba_d[REFRESH_BITS-1:0]    = rfsh_q;
                        end else begin
                            ba_d   = addr_d;
                            m1_n_d = 1'b0;
                            rd_n_d = 1'b0;
                        end
                    end
                    CMD_MRD: begin
                        ba_d     = addr_d;
                        mreq_n_d = 1'b0;
                        rd_n_d   = 1'b0;
                    end
                    CMD_MWR: begin
                        ba_d     = addr_d;
                        mreq_n_d = 1'b0;
                        bd_oe_d  = 1'b1;
                        bd_o_d   = wdata_d;
                        wr_n_d   = (state_d == ST_T1);
                    end
                    CMD_IORD: begin
                        ba_d     = addr_d;
                        iorq_n_d = (state_d == ST_T1);
                        rd_n_d   = (state_d == ST_T1);
                    end
                    CMD_IOWR: begin
                        ba_d     = addr_d;
                        iorq_n_d = (state_d == ST_T1);
                        wr_n_d   = (state_d == ST_T1);
                        bd_oe_d  = 1'b1;
                        bd_o_d   = wdata_d;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            kind_q     <= CMD_M1;
            addr_q     <= '0;
            wdata_q    <= '0;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            rfsh_q     <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            BA         <= '0;
            BD_O       <= '0;
            BD_OE      <= 1'b0;
            BMREQ_N    <= 1'b1;
            IORQ_N     <= 1'b1;
            BRD_N      <= 1'b1;
            N_BWR      <= 1'b1;
            BM1_N      <= 1'b1;
            BRFSH_N    <= 1'b1;
            BUS_OE     <= 1'b1;
            BUSAK_N    <= 1'b1;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            rfsh_q     <= rfsh_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            BA         <= ba_d;
            BD_O       <= bd_o_d;
            BD_OE      <= bd_oe_d;
            BMREQ_N    <= mreq_n_d;
            IORQ_N     <= iorq_n_d;
            BRD_N      <= rd_n_d;
            N_BWR      <= wr_n_d;
            BM1_N      <= m1_n_d;
            BRFSH_N    <= rfsh_n_d;
            BUS_OE     <= bus_oe_d;
            BUSAK_N    <= busak_n_d;
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Self-checking bench for z80_bus_master: vector table of bus cycles with a response
// scoreboard, plus hand-written reset, refresh-wrap and bus-release sequences.
module tb_z80_bus_master;

    logic        B_PHI = 1'b0;
    logic        RST_N = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_type = 3'd0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] BA;
    logic [7:0]  BD_O;
    logic        BD_OE;
    logic [7:0]  BD_I = 8'h00;
    logic        BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N;
    logic        BUS_OE;
    logic        WAIT_N = 1'b1;
    logic        BUSRQ_N = 1'b1;
    logic        BUSAK_N;

    z80_bus_master dut (
        .B_PHI(B_PHI), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .BA(BA), .BD_O(BD_O), .BD_OE(BD_OE), .BD_I(BD_I),
        .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR),
        .BM1_N(BM1_N), .BRFSH_N(BRFSH_N), .BUS_OE(BUS_OE),
        .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N)
    );

    always #5 B_PHI = ~B_PHI;

    typedef struct {
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  bdi;
        int          waits;
        int          busrq_edge;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_mreq, exp_rd, exp_wr, exp_iorq, exp_m1, exp_rfsh, exp_bdoe;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t sb_e;

    int n_cmp = 0;
    int n_bad = 0;

    int n_mreq, n_rd, n_wr, n_iorq, n_m1, n_rfsh, n_bdoe, n_bdo_bad;
    logic [15:0] first_ba, rfsh_ba;
    logic        ba_seen = 1'b0, rfsh_seen = 1'b0;
    logic [7:0]  cur_wdata = 8'h00;
    logic [6:0]  rfsh_model = 7'd0;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] typ, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic [7:0] bdi, input int waits,
                                input logic [7:0] rdata, input logic err,
                                input int mreq, input int rd, input int wr, input int iorq,
                                input int m1, input int rfsh, input int bdoe);
        vec_t v;
        v.typ = typ; v.addr = addr; v.wdata = wdata; v.bdi = bdi; v.waits = waits;
        v.busrq_edge = 0; v.exp_rdata = rdata; v.exp_err = err;
        v.exp_mreq = mreq; v.exp_rd = rd; v.exp_wr = wr; v.exp_iorq = iorq;
        v.exp_m1 = m1; v.exp_rfsh = rfsh; v.exp_bdoe = bdoe;
        return v;
    endfunction

    // Bus monitor and response scoreboard, sampled on the falling edge.
    always @(negedge B_PHI) begin
        if (RST_N) begin
            if (!BMREQ_N) n_mreq++;
            if (!BRD_N)   n_rd++;
            if (!N_BWR)   n_wr++;
            if (!IORQ_N)  n_iorq++;
            if (!BM1_N)   n_m1++;
            if (!BRFSH_N) n_rfsh++;
            if (BD_OE) begin
                n_bdoe++;
                if (BD_O !== cur_wdata) n_bdo_bad++;
            end
            if ((!BMREQ_N || !IORQ_N) && BRFSH_N && !ba_seen) begin
                first_ba = BA;
                ba_seen  = 1'b1;
            end
            if (!BRFSH_N && !rfsh_seen) begin
                rfsh_ba   = BA;
                rfsh_seen = 1'b1;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%02h err=%0b, expected no response",
                             rsp_rdata, rsp_err);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, sb_e.rdata});
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, sb_e.err});
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        bit   done;
        int   ws;
        rsp_t r;
        check($sformatf("v%0d_ready", idx), {31'h0, cmd_ready}, 32'd1);
        cmd_type  = v.typ;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        BD_I      = v.bdi;
        cur_wdata = v.wdata;
        n_mreq = 0; n_rd = 0; n_wr = 0; n_iorq = 0; n_m1 = 0; n_rfsh = 0; n_bdoe = 0; n_bdo_bad = 0;
        ba_seen = 1'b0;
        rfsh_seen = 1'b0;
        r.rdata = v.exp_rdata;
        r.err   = v.exp_err;
        exp_q.push_back(r);
        ws = (v.typ == 3'd3 || v.typ == 3'd4) ? 3 : 2;
        WAIT_N    = 1'b1;
        cmd_valid = 1'b1;
        @(posedge B_PHI); #1;
        cmd_valid = 1'b0;
        done = rsp_valid;
        for (int e = 1; e <= 60 && !done; e++) begin
            WAIT_N = !(e >= ws && e < ws + v.waits);
            if (v.busrq_edge != 0 && e >= v.busrq_edge) BUSRQ_N = 1'b0;
            @(posedge B_PHI); #1;
            done = rsp_valid;
        end
        WAIT_N = 1'b1;
        check($sformatf("v%0d_done", idx), {31'h0, done}, 32'd1);
        check($sformatf("v%0d_mreq_cnt", idx), n_mreq, v.exp_mreq);
        check($sformatf("v%0d_rd_cnt", idx), n_rd, v.exp_rd);
        check($sformatf("v%0d_wr_cnt", idx), n_wr, v.exp_wr);
        check($sformatf("v%0d_iorq_cnt", idx), n_iorq, v.exp_iorq);
        check($sformatf("v%0d_m1_cnt", idx), n_m1, v.exp_m1);
        check($sformatf("v%0d_rfsh_cnt", idx), n_rfsh, v.exp_rfsh);
        check($sformatf("v%0d_bdoe_cnt", idx), n_bdoe, v.exp_bdoe);
        check($sformatf("v%0d_bdo_stable", idx), n_bdo_bad, 0);
        if (v.exp_mreq + v.exp_iorq > 0)
            check($sformatf("v%0d_addr", idx), {16'h0, first_ba}, {16'h0, v.addr});
        if (v.typ == 3'd0 && !v.exp_err) begin
            check($sformatf("v%0d_rfsh_ba", idx), {16'h0, rfsh_ba}, {25'h0, rfsh_model});
            rfsh_model = rfsh_model + 7'd1;
        end
    endtask

    initial begin
        vec_t bv, m1v;

        //             typ   addr      wdata  bdi    wt  rdata  err mreq rd wr iorq m1 rfsh bdoe
        tbl[0]  = mk(3'd1, 16'h8000, 8'h00, 8'hA5, 0,  8'hA5, 0,  3,  3, 0, 0,   0, 0,   0);
        tbl[1]  = mk(3'd0, 16'h0000, 8'h00, 8'h3E, 0,  8'h3E, 0,  4,  2, 0, 0,   2, 2,   0);
        tbl[2]  = mk(3'd0, 16'h0001, 8'h00, 8'h01, 0,  8'h01, 0,  4,  2, 0, 0,   2, 2,   0);
        tbl[3]  = mk(3'd0, 16'h0002, 8'h00, 8'h76, 0,  8'h76, 0,  4,  2, 0, 0,   2, 2,   0);
        tbl[4]  = mk(3'd2, 16'h2000, 8'h5A, 8'hFF, 2,  8'h00, 0,  5,  0, 4, 0,   0, 0,   5);
        tbl[5]  = mk(3'd3, 16'h0040, 8'h00, 8'h3C, 0,  8'h3C, 0,  0,  3, 0, 3,   0, 0,   0);
        tbl[6]  = mk(3'd4, 16'h0040, 8'h3F, 8'h00, 0,  8'h00, 0,  0,  0, 3, 3,   0, 0,   4);
        tbl[7]  = mk(3'd1, 16'h1234, 8'h00, 8'hC3, 1,  8'hC3, 0,  4,  4, 0, 0,   0, 0,   0);
        tbl[8]  = mk(3'd0, 16'h0100, 8'h00, 8'hED, 1,  8'hED, 0,  5,  3, 0, 0,   3, 2,   0);
        tbl[9]  = mk(3'd5, 16'h0000, 8'h00, 8'h11, 0,  8'h00, 1,  0,  0, 0, 0,   0, 0,   0);
        tbl[10] = mk(3'd3, 16'h0041, 8'h00, 8'h99, 99, 8'h00, 1,  0, 17, 0, 17,  0, 0,   0);
        tbl[11] = mk(3'd4, 16'h00FF, 8'hC0, 8'h00, 2,  8'h00, 0,  0,  0, 5, 5,   0, 0,   6);
        tbl[12] = mk(3'd2, 16'hFFFF, 8'hA3, 8'h00, 0,  8'h00, 0,  3,  0, 2, 0,   0, 0,   3);
        tbl[13] = mk(3'd0, 16'h0003, 8'h00, 8'h00, 2,  8'h00, 0,  6,  4, 0, 0,   4, 2,   0);
        tbl[14] = mk(3'd1, 16'h9000, 8'h00, 8'h42, 99, 8'h00, 1, 18, 18, 0, 0,   0, 0,   0);

        // Power-on reset values.
        #2 RST_N = 1'b0;
        #1;
        check("rst_strobes", {26'h0, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N}, 32'h3F);
        check("rst_busak", {31'h0, BUSAK_N}, 32'd1);
        check("rst_bus_oe", {31'h0, BUS_OE}, 32'd1);
        check("rst_ba", {16'h0, BA}, 32'h0);
        check("rst_bd", {23'h0, BD_OE, BD_O}, 32'h0);
        check("rst_ready", {31'h0, cmd_ready}, 32'd1);
        check("rst_rsp", {22'h0, rsp_valid, rsp_err, rsp_rdata}, 32'h0);
        repeat (2) @(posedge B_PHI);
        #1 RST_N = 1'b1;
        @(posedge B_PHI); #1;

        // Reset during T2 of a MEM read drops the cycle.
        cmd_type = 3'd1; cmd_addr = 16'h8000; BD_I = 8'hA5; cmd_valid = 1'b1;
        @(posedge B_PHI); #1;
        cmd_valid = 1'b0;
        check("rr_t1_mreq", {31'h0, BMREQ_N}, 32'd0);
        @(posedge B_PHI); #1;
        RST_N = 1'b0;
        #1;
        check("rr_strobes", {26'h0, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N}, 32'h3F);
        check("rr_busak", {31'h0, BUSAK_N}, 32'd1);
        check("rr_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rr_ba", {16'h0, BA}, 32'h0);
        repeat (2) @(posedge B_PHI);
        #1 RST_N = 1'b1;
        @(posedge B_PHI); #1;
        check("rr_ready", {31'h0, cmd_ready}, 32'd1);
        check("rr_no_rsp", {31'h0, rsp_valid}, 32'd0);

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

        // Refresh counter runs through 127 and wraps to 0.
        m1v = mk(3'd0, 16'h0010, 8'h00, 8'h5B, 0, 8'h5B, 0, 4, 2, 0, 0, 2, 2, 0);
        do begin
            run_vec(100, m1v);
        end while (rfsh_model != 7'd0);
        run_vec(101, m1v);

        // BUSRQ_N dropped during T2: cycle completes, then the bus is released.
        bv = mk(3'd1, 16'h4000, 8'h00, 8'h77, 0, 8'h77, 0, 3, 3, 0, 0, 0, 0, 0);
        bv.busrq_edge = 2;
        run_vec(102, bv);
        check("brel_busak", {31'h0, BUSAK_N}, 32'd0);
        check("brel_bus_oe", {31'h0, BUS_OE}, 32'd0);
        check("brel_ready", {31'h0, cmd_ready}, 32'd0);
        check("brel_strobes", {26'h0, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N}, 32'h3F);
        check("brel_bd_oe", {31'h0, BD_OE}, 32'd0);
        repeat (3) @(posedge B_PHI);
        #1;
        check("brel_hold", {31'h0, BUSAK_N}, 32'd0);
        BUSRQ_N = 1'b1;
        @(posedge B_PHI); #1;
        check("brel_exit_busak", {31'h0, BUSAK_N}, 32'd1);
        check("brel_exit_bus_oe", {31'h0, BUS_OE}, 32'd1);
        check("brel_exit_ready", {31'h0, cmd_ready}, 32'd1);

        // Command and bus request together in IDLE: release wins, command waits.
        cmd_type = 3'd1; cmd_addr = 16'h5555; BD_I = 8'h5C;
        BUSRQ_N = 1'b0;
        cmd_valid = 1'b1;
        @(posedge B_PHI); #1;
        check("sim_busak", {31'h0, BUSAK_N}, 32'd0);
        check("sim_ready", {31'h0, cmd_ready}, 32'd0);
        check("sim_no_mreq", {31'h0, BMREQ_N}, 32'd1);
        @(posedge B_PHI); #1;
        check("sim_hold_mreq", {31'h0, BMREQ_N}, 32'd1);
        BUSRQ_N = 1'b1;
        @(posedge B_PHI); #1;
        check("sim_exit_busak", {31'h0, BUSAK_N}, 32'd1);
        check("sim_exit_ready", {31'h0, cmd_ready}, 32'd1);
        run_vec(103, mk(3'd1, 16'h5555, 8'h00, 8'h5C, 0, 8'h5C, 0, 3, 3, 0, 0, 0, 0, 0));

        repeat (2) @(posedge B_PHI);
        #1;
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
